// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master (IFU/LSU) round-robin arbiter onto a single memory slave port
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rsp_valid,
    input  logic                ifu_rsp_ready,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_rsp_valid,
    input  logic                lsu_rsp_ready,

    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,

    output logic                s_req_valid,
    input  logic                s_req_ready,
    output logic [ADDR_W-1:0]   s_addr,
    output logic                s_wen,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wmask,
    input  logic                s_rsp_valid,
    output logic                s_rsp_ready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic                s_err,

    output logic                owner,
    output logic                proto_err
);

    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic grant_ifu;
    logic grant_lsu;
    logic owner_rsp_ready;

    // On a tie the master that did not win last time gets the port.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (state_q == ST_IDLE) begin
            grant_ifu = ifu_req_valid && (!lsu_req_valid || owner);
            grant_lsu = lsu_req_valid && (!ifu_req_valid || !owner);
        end
    end

    always_comb begin
        owner_rsp_ready = owner ? lsu_rsp_ready : ifu_rsp_ready;
    end

    always_comb begin
        state_d       = state_q;
        ifu_req_ready = grant_ifu;
        lsu_req_ready = grant_lsu;
        s_req_valid   = 1'b0;
        s_rsp_ready   = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_rsp_valid = 1'b0;
        rsp_rdata     = s_rdata;
        rsp_err       = s_err;
        case (state_q)
            ST_IDLE: begin
                if (grant_ifu || grant_lsu) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                s_req_valid = 1'b1;
                if (s_req_ready) begin
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                s_rsp_ready   = owner_rsp_ready;
                ifu_rsp_valid = s_rsp_valid && !owner;
                lsu_rsp_valid = s_rsp_valid && owner;
                if (s_rsp_valid && owner_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload is captured once at grant and held for the whole transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner   <= 1'b1;
            s_addr  <= '0;
            s_wen   <= 1'b0;
            s_wdata <= '0;
            s_wmask <= '0;
        end else if (grant_ifu) begin
            owner   <= 1'b0;
            s_addr  <= ifu_addr;
            s_wen   <= 1'b0;
            s_wdata <= '0;
            s_wmask <= {MASK_W{1'b0}};
        end else if (grant_lsu) begin
            owner   <= 1'b1;
            s_addr  <= lsu_addr;
            s_wen   <= lsu_wen;
            s_wdata <= lsu_wdata;
            s_wmask <= lsu_wmask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if (s_rsp_valid && (state_q != ST_RSP)) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic                ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
    logic [ADDR_W-1:0]   ifu_addr;
    logic                lsu_req_valid, lsu_req_ready, lsu_rsp_valid, lsu_rsp_ready;
    logic [ADDR_W-1:0]   lsu_addr;
    logic                lsu_wen;
    logic [DATA_W-1:0]   lsu_wdata;
    logic [DATA_W/8-1:0] lsu_wmask;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_err;
    logic                s_req_valid, s_req_ready;
    logic [ADDR_W-1:0]   s_addr;
    logic                s_wen;
    logic [DATA_W-1:0]   s_wdata;
    logic [DATA_W/8-1:0] s_wmask;
    logic                s_rsp_valid, s_rsp_ready;
    logic [DATA_W-1:0]   s_rdata;
    logic                s_err;
    logic                owner, proto_err;

    int checks   = 0;
    int failures = 0;

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_addr(s_addr),
        .s_wen(s_wen), .s_wdata(s_wdata), .s_wmask(s_wmask),
        .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready),
        .s_rdata(s_rdata), .s_err(s_err),
        .owner(owner), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ifu_req_valid = 0; ifu_addr = '0; ifu_rsp_ready = 0;
        lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
        lsu_rsp_ready = 0;
        s_req_ready = 0; s_rsp_valid = 0; s_rdata = '0; s_err = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        settle();

        chk("rst_owner", owner, 1'b1);
        chk("rst_proto_err", proto_err, 1'b0);
        chk("rst_s_req_valid", s_req_valid, 1'b0);
        chk("rst_s_rsp_ready", s_rsp_ready, 1'b0);
        chk("rst_s_addr", s_addr, 32'h0);
        chk("rst_rsp_valids", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);

        ifu_req_valid = 1; ifu_addr = 32'h8000_0000; ifu_rsp_ready = 1;
        settle();
        chk("t1_ifu_req_ready", ifu_req_ready, 1'b1);
        chk("t1_lsu_req_ready", lsu_req_ready, 1'b0);
        tick();
        ifu_req_valid = 0; ifu_addr = 32'h1234_5678; s_req_ready = 1;
        settle();
        chk("t1_s_req_valid", s_req_valid, 1'b1);
        chk("t1_s_addr", s_addr, 32'h8000_0000);
        chk("t1_s_wen", s_wen, 1'b0);
        chk("t1_owner", owner, 1'b0);
        chk("t1_no_ready_in_req", ifu_req_ready, 1'b0);
        tick();
        s_req_ready = 0;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("t1_wait_ifu_rsp_valid", ifu_rsp_valid, 1'b0);
            chk("t1_wait_s_req_valid", s_req_valid, 1'b0);
            tick();
        end
        s_rsp_valid = 1; s_rdata = 32'h0000_0413; s_err = 0;
        settle();
        chk("t1_ifu_rsp_valid", ifu_rsp_valid, 1'b1);
        chk("t1_rsp_rdata", rsp_rdata, 32'h0000_0413);
        chk("t1_rsp_err", rsp_err, 1'b0);
        chk("t1_lsu_rsp_valid", lsu_rsp_valid, 1'b0);
        chk("t1_s_rsp_ready", s_rsp_ready, 1'b1);
        tick();
        s_rsp_valid = 0;
        settle();
        chk("t1_back_idle", s_rsp_ready, 1'b0);
        chk("t1_proto_err", proto_err, 1'b0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        ifu_req_valid = 1; ifu_addr = 32'h0000_1000;
        lsu_req_valid = 1; lsu_addr = 32'h0000_2000; lsu_wen = 0;
        lsu_rsp_ready = 1; ifu_rsp_ready = 1;
        for (int t = 0; t < 4; t++) begin
            settle();
            chk("t2_ifu_req_ready", ifu_req_ready, (t % 2 == 0));
            chk("t2_lsu_req_ready", lsu_req_ready, (t % 2 == 1));
            tick();
            s_req_ready = 1;
            settle();
            chk("t2_owner", owner, (t % 2 == 1));
            chk("t2_s_addr", s_addr, ((t % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000));
            tick();
            s_req_ready = 0; s_rsp_valid = 1; s_rdata = 32'hA0 + t;
            settle();
            chk("t2_ifu_rsp_valid", ifu_rsp_valid, (t % 2 == 0));
            chk("t2_lsu_rsp_valid", lsu_rsp_valid, (t % 2 == 1));
            tick();
            s_rsp_valid = 0;
        end
        ifu_req_valid = 0; lsu_req_valid = 0;
        settle();
        chk("t2_proto_err", proto_err, 1'b0);

        lsu_req_valid = 1; lsu_addr = 32'h8000_0102; lsu_wen = 1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b1100; lsu_rsp_ready = 0;
        settle();
        chk("t3_lsu_req_ready", lsu_req_ready, 1'b1);
        tick();
        lsu_req_valid = 0; lsu_addr = 32'h0; lsu_wdata = 32'h5555_5555; lsu_wmask = 4'b0011; lsu_wen = 0;
        s_req_ready = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t3_stall_s_req_valid", s_req_valid, 1'b1);
            chk("t3_stall_s_addr", s_addr, 32'h8000_0102);
            chk("t3_stall_s_wdata", s_wdata, 32'hDEAD_BEEF);
            chk("t3_stall_s_wmask", s_wmask, 4'b1100);
            chk("t3_stall_s_wen", s_wen, 1'b1);
            tick();
        end
        s_req_ready = 1;
        settle();
        chk("t3_s_req_valid_hs", s_req_valid, 1'b1);
        tick();
        s_req_ready = 0; s_rsp_valid = 1; s_err = 1; s_rdata = 32'hFFFF_0000;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("t4_hold_s_rsp_ready", s_rsp_ready, 1'b0);
            chk("t4_hold_lsu_rsp_valid", lsu_rsp_valid, 1'b1);
            chk("t4_hold_ifu_rsp_valid", ifu_rsp_valid, 1'b0);
            chk("t4_hold_rsp_err", rsp_err, 1'b1);
            tick();
        end
        lsu_rsp_ready = 1;
        settle();
        chk("t4_s_rsp_ready", s_rsp_ready, 1'b1);
        chk("t4_rsp_err", rsp_err, 1'b1);
        tick();
        s_rsp_valid = 0; s_err = 0;
        settle();
        chk("t4_idle_s_rsp_ready", s_rsp_ready, 1'b0);
        chk("t4_idle_lsu_rsp_valid", lsu_rsp_valid, 1'b0);
        chk("t4_proto_err", proto_err, 1'b0);

        ifu_req_valid = 1; ifu_addr = 32'h4000_0040; ifu_rsp_ready = 1;
        settle();
        chk("t5_ifu_req_ready", ifu_req_ready, 1'b1);
        tick();
        ifu_req_valid = 0; s_req_ready = 1;
        tick();
        s_req_ready = 0; s_rsp_valid = 1; s_rdata = 32'h77;
        settle();
        chk("t5_in_rsp", ifu_rsp_valid, 1'b1);
        rst = 1'b1;
        settle();
        chk("t5_rst_ifu_rsp_valid", ifu_rsp_valid, 1'b0);
        chk("t5_rst_s_rsp_ready", s_rsp_ready, 1'b0);
        chk("t5_rst_s_req_valid", s_req_valid, 1'b0);
        chk("t5_rst_owner", owner, 1'b1);
        s_rsp_valid = 0;
        tick();
        rst = 1'b0;
        settle();
        chk("t5_rel_owner", owner, 1'b1);
        chk("t5_rel_proto_err", proto_err, 1'b0);
        chk("t5_rel_s_addr", s_addr, 32'h0);
        lsu_req_valid = 1; lsu_addr = 32'h10; ifu_req_valid = 1;
        settle();
        chk("t5_rel_tie_ifu", {ifu_req_ready, lsu_req_ready}, 2'b10);
        ifu_req_valid = 0; lsu_req_valid = 0;
        settle();

        s_rsp_valid = 1; ifu_rsp_ready = 1; lsu_rsp_ready = 1;
        settle();
        chk("t6_ifu_rsp_valid", ifu_rsp_valid, 1'b0);
        chk("t6_lsu_rsp_valid", lsu_rsp_valid, 1'b0);
        chk("t6_s_rsp_ready", s_rsp_ready, 1'b0);
        tick();
        s_rsp_valid = 0;
        settle();
        chk("t6_proto_err_set", proto_err, 1'b1);
        repeat (3) tick();
        chk("t6_proto_err_sticky", proto_err, 1'b1);
        chk("t6_still_idle", s_req_valid, 1'b0);
        rst = 1'b1;
        settle();
        chk("t6_rst_proto_err", proto_err, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
